// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
//   Bundle of every signal between the two requesters (A = CPU, B = DMA /
//   front-panel loader), the arbiter and the single-port byte RAM.
//
//   Requester A / B (x = a or b):
//     x_req    request, held until the ack cycle
//     x_we     write enable for the request
//     x_lock   keep the port for a burst of back-to-back accesses
//     x_addr   access address
//     x_wdata  write data
//     x_ack    one-cycle completion pulse
//     x_rdata  registered read data, holds until the next ack
//     x_gnt    requester owns the RAM port this cycle
//   RAM side:
//     mem_address, mem_write_en, mem_data_in   to the RAM
//     mem_data_out                             combinational read data
//
//   Modports:
//     slave   arbiter view
//     master  requester + RAM view (testbench / system glue)
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              a_req;
    logic              a_we;
    logic              a_lock;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_ack;
    logic [DATA_W-1:0] a_rdata;
    logic              a_gnt;

    logic              b_req;
    logic              b_we;
    logic              b_lock;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_ack;
    logic [DATA_W-1:0] b_rdata;
    logic              b_gnt;

    logic [ADDR_W-1:0] mem_address;
    logic              mem_write_en;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;

    modport slave (
        input  a_req, a_we, a_lock, a_addr, a_wdata,
        input  b_req, b_we, b_lock, b_addr, b_wdata,
        input  mem_data_out,
        output a_ack, a_rdata, a_gnt,
        output b_ack, b_rdata, b_gnt,
        output mem_address, mem_write_en, mem_data_in
    );

    modport master (
        output a_req, a_we, a_lock, a_addr, a_wdata,
        output b_req, b_we, b_lock, b_addr, b_wdata,
        output mem_data_out,
        input  a_ack, a_rdata, a_gnt,
        input  b_ack, b_rdata, b_gnt,
        input  mem_address, mem_write_en, mem_data_in
    );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port byte RAM between requester A and requester B.
//   One access at a time; an access cycle drives the RAM port from the owner,
//   and the following cycle presents a one-cycle ack with registered read
//   data. Locked bursts get one access per cycle, but after MAX_HOLD
//   consecutive accesses the tenure ends if the other side is waiting.
//
//   Ports:
//     clock    system clock, rising edge
//     reset_n  asynchronous active-low reset
//     bus      mem_arbiter_if.slave (requesters A/B and RAM port)
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    mem_arbiter_if.slave bus
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W:0] MAX_HOLD_C = (HOLD_W + 1)'(MAX_HOLD);
    localparam logic [HOLD_W:0] ONE_C      = (HOLD_W + 1)'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC_A = 2'd1,
        ACC_B = 2'd2
    } state_t;

    typedef enum logic {
        SEL_A = 1'b0,
        SEL_B = 1'b1
    } sel_t;

    state_t              state_q, state_d;
    sel_t                last_q, last_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                a_ack_q, a_ack_d;
    logic                b_ack_q, b_ack_d;
    logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;

    logic                a_vis, b_vis;
    logic                acc_a, acc_b;
    logic                hold_lim;
    logic [HOLD_W-1:0]   hold_next;

    // True when this access completes MAX_HOLD accesses in the tenure.
    function automatic logic hold_limit(input logic [HOLD_W-1:0] cnt);
        logic [HOLD_W:0] inc;
        inc = {1'b0, cnt} + ONE_C;
        return (inc >= MAX_HOLD_C);
    endfunction

    // Tenure counter increment, pinned at MAX_HOLD.
    function automatic logic [HOLD_W-1:0] hold_sat_inc(input logic [HOLD_W-1:0] cnt);
        logic [HOLD_W:0] inc;
        inc = {1'b0, cnt} + ONE_C;
        if (inc >= MAX_HOLD_C) begin
            return MAX_HOLD_C[HOLD_W-1:0];
        end
        return inc[HOLD_W-1:0];
    endfunction

    // An access happens only while the owner still holds its request.
    assign acc_a = (state_q == ACC_A) && bus.a_req;
    assign acc_b = (state_q == ACC_B) && bus.b_req;

    // A requester being acked this cycle is still presenting the finished
    // transaction (or its next one); masking it hands the slot to the other.
    assign a_vis = bus.a_req && !a_ack_q;
    assign b_vis = bus.b_req && !b_ack_q;

    assign hold_lim  = hold_limit(hold_q);
    assign hold_next = hold_sat_inc(hold_q);

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        hold_d    = hold_q;
        a_ack_d   = 1'b0;
        b_ack_d   = 1'b0;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (a_vis && (!b_vis || (last_q == SEL_B))) begin
                    state_d = ACC_A;
                    hold_d  = '0;
                end else if (b_vis) begin
                    state_d = ACC_B;
                    hold_d  = '0;
                end
            end
            ACC_A: begin
                if (bus.a_req) begin
                    a_ack_d   = 1'b1;
                    a_rdata_d = bus.mem_data_out;
                    last_d    = SEL_A;
                    hold_d    = hold_next;
                    // Stay only if locked and not forced out by a waiting B.
                    if (bus.a_lock && !(hold_lim && bus.b_req)) begin
                        state_d = ACC_A;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACC_B: begin
                if (bus.b_req) begin
                    b_ack_d   = 1'b1;
                    b_rdata_d = bus.mem_data_out;
                    last_d    = SEL_B;
                    hold_d    = hold_next;
                    if (bus.b_lock && !(hold_lim && bus.a_req)) begin
                        state_d = ACC_B;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            last_q    <= SEL_B;
            hold_q    <= '0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            a_ack_q   <= a_ack_d;
            b_ack_q   <= b_ack_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    // RAM port is combinational from state so a reset pulse kills a write
    // before the edge that would commit it.
    always_comb begin
        bus.mem_address  = '0;
        bus.mem_data_in  = '0;
        bus.mem_write_en = 1'b0;
        if (acc_a) begin
            bus.mem_address  = bus.a_addr;
            bus.mem_data_in  = bus.a_wdata;
            bus.mem_write_en = bus.a_we;
        end else if (acc_b) begin
            bus.mem_address  = bus.b_addr;
            bus.mem_data_in  = bus.b_wdata;
            bus.mem_write_en = bus.b_we;
        end
    end

    assign bus.a_gnt   = (state_q == ACC_A);
    assign bus.b_gnt   = (state_q == ACC_B);
    assign bus.a_ack   = a_ack_q;
    assign bus.b_ack   = b_ack_q;
    assign bus.a_rdata = a_rdata_q;
    assign bus.b_rdata = b_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter with a behavioural byte RAM. Inputs change
//   1 ns after the rising edge; outputs are checked 1 ns after that.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    logic clock = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    // Byte RAM: combinational read, write on the rising edge. The pre_* port
    // loads known contents while the arbiter is held in reset.
    logic [7:0]  ram [0:65535];
    logic        pre_we   = 1'b0;
    logic [15:0] pre_addr = 16'h0000;
    logic [7:0]  pre_data = 8'h00;

    assign bus.mem_data_out = ram[bus.mem_address];

    always @(posedge clock) begin
        if (bus.mem_write_en) ram[bus.mem_address] <= bus.mem_data_in;
        else if (pre_we)      ram[pre_addr] <= pre_data;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %04h expected %04h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic set_a(input logic req, input logic we, input logic lock,
                         input logic [15:0] addr, input logic [7:0] wd);
        bus.a_req = req; bus.a_we = we; bus.a_lock = lock;
        bus.a_addr = addr; bus.a_wdata = wd;
    endtask

    task automatic set_b(input logic req, input logic we, input logic lock,
                         input logic [15:0] addr, input logic [7:0] wd);
        bus.b_req = req; bus.b_we = we; bus.b_lock = lock;
        bus.b_addr = addr; bus.b_wdata = wd;
    endtask

    function automatic logic [1:0] gnt();
        return {bus.a_gnt, bus.b_gnt};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        // ---------------- reset with both requesting, RAM preload ----------
        reset_n = 1'b0;
        set_a(1'b1, 1'b1, 1'b0, 16'h0005, 8'hAA);
        set_b(1'b1, 1'b1, 1'b0, 16'h0006, 8'hBB);
        pre_we = 1'b1; pre_addr = 16'h0100; pre_data = 8'h11;
        cyc(); pre_addr = 16'h0101; pre_data = 8'h33;
        cyc(); pre_addr = 16'h0200; pre_data = 8'h22;
        cyc(); pre_addr = 16'h0020; pre_data = 8'h5C;
        cyc(); pre_we = 1'b0;
        #1;
        chk1("rst a_ack", bus.a_ack, 1'b0);
        chk1("rst b_ack", bus.b_ack, 1'b0);
        chk8("rst a_rdata", bus.a_rdata, 8'h00);
        chk8("rst b_rdata", bus.b_rdata, 8'h00);
        chk2("rst gnt", gnt(), 2'b00);
        chk1("rst we", bus.mem_write_en, 1'b0);

        set_a(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        set_b(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        reset_n = 1'b1;
        cyc(); cyc(); #1;
        chk2("idle gnt", gnt(), 2'b00);
        chk1("idle we", bus.mem_write_en, 1'b0);
        chk16("idle addr", bus.mem_address, 16'h0000);
        chk1("idle a_ack", bus.a_ack, 1'b0);
        chk1("idle b_ack", bus.b_ack, 1'b0);

        // ---------------- simultaneous reads alternate A,B,A,B -------------
        cyc();
        set_a(1'b1, 1'b0, 1'b0, 16'h0100, 8'h00);
        set_b(1'b1, 1'b0, 1'b0, 16'h0200, 8'h00);
        #1; chk2("alt c0 gnt", gnt(), 2'b00);
        cyc(); chk2("alt c1 gnt", gnt(), 2'b10);
        chk16("alt c1 addr", bus.mem_address, 16'h0100);
        cyc(); set_a(1'b1, 1'b0, 1'b0, 16'h0101, 8'h00); #1;
        chk1("alt c2 a_ack", bus.a_ack, 1'b1);
        chk8("alt c2 a_rdata", bus.a_rdata, 8'h11);
        chk2("alt c2 gnt", gnt(), 2'b00);
        cyc(); chk2("alt c3 gnt", gnt(), 2'b01);
        chk16("alt c3 addr", bus.mem_address, 16'h0200);
        chk1("alt c3 a_ack", bus.a_ack, 1'b0);
        cyc(); chk1("alt c4 b_ack", bus.b_ack, 1'b1);
        chk8("alt c4 b_rdata", bus.b_rdata, 8'h22);
        chk8("alt c4 a_rdata hold", bus.a_rdata, 8'h11);
        chk2("alt c4 gnt", gnt(), 2'b00);
        cyc(); chk2("alt c5 gnt", gnt(), 2'b10);
        chk16("alt c5 addr", bus.mem_address, 16'h0101);
        cyc(); set_a(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00); #1;
        chk1("alt c6 a_ack", bus.a_ack, 1'b1);
        chk8("alt c6 a_rdata", bus.a_rdata, 8'h33);
        chk1("alt c6 b_ack", bus.b_ack, 1'b0);
        chk2("alt c6 gnt", gnt(), 2'b00);
        cyc(); chk2("alt c7 gnt", gnt(), 2'b01);
        cyc(); set_b(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00); #1;
        chk1("alt c8 b_ack", bus.b_ack, 1'b1);
        chk8("alt c8 b_rdata", bus.b_rdata, 8'h22);
        cyc(); chk2("alt c9 gnt", gnt(), 2'b00);
        chk1("alt c9 b_ack", bus.b_ack, 1'b0);

        // ---------------- A write then read back ---------------------------
        cyc();
        set_a(1'b1, 1'b1, 1'b0, 16'h005A, 8'h48);
        #1; chk2("wr c0 gnt", gnt(), 2'b00);
        chk1("wr c0 we", bus.mem_write_en, 1'b0);
        cyc(); chk2("wr c1 gnt", gnt(), 2'b10);
        chk1("wr c1 we", bus.mem_write_en, 1'b1);
        chk16("wr c1 addr", bus.mem_address, 16'h005A);
        chk8("wr c1 data", bus.mem_data_in, 8'h48);
        cyc(); set_a(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00); #1;
        chk1("wr c2 a_ack", bus.a_ack, 1'b1);
        chk1("wr c2 we", bus.mem_write_en, 1'b0);
        chk8("wr ram[5A]", ram[16'h005A], 8'h48);
        cyc(); chk1("wr c3 a_ack", bus.a_ack, 1'b0);
        cyc();
        set_a(1'b1, 1'b0, 1'b0, 16'h005A, 8'h00);
        cyc(); chk2("rd c1 gnt", gnt(), 2'b10);
        chk1("rd c1 we", bus.mem_write_en, 1'b0);
        cyc(); set_a(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00); #1;
        chk1("rd c2 a_ack", bus.a_ack, 1'b1);
        chk8("rd c2 a_rdata", bus.a_rdata, 8'h48);

        // ---------------- B locked burst interrupted by A ------------------
        cyc(); cyc();
        set_b(1'b1, 1'b1, 1'b1, 16'h0010, 8'hB0);
        set_a(1'b1, 1'b0, 1'b0, 16'h0100, 8'h00);
        #1; chk2("hold c0 gnt", gnt(), 2'b00);
        cyc(); chk2("hold c1 gnt", gnt(), 2'b01);
        chk16("hold c1 addr", bus.mem_address, 16'h0010);
        chk1("hold c1 we", bus.mem_write_en, 1'b1);
        cyc(); set_b(1'b1, 1'b1, 1'b1, 16'h0011, 8'hB1); #1;
        chk1("hold c2 b_ack", bus.b_ack, 1'b1);
        chk2("hold c2 gnt", gnt(), 2'b01);
        chk16("hold c2 addr", bus.mem_address, 16'h0011);
        cyc(); set_b(1'b1, 1'b1, 1'b1, 16'h0012, 8'hB2); #1;
        chk1("hold c3 b_ack", bus.b_ack, 1'b1);
        chk16("hold c3 addr", bus.mem_address, 16'h0012);
        cyc(); set_b(1'b1, 1'b1, 1'b1, 16'h0013, 8'hB3); #1;
        chk1("hold c4 b_ack", bus.b_ack, 1'b1);
        chk2("hold c4 gnt", gnt(), 2'b01);
        cyc(); set_b(1'b1, 1'b1, 1'b1, 16'h0014, 8'hB4); #1;
        chk1("hold c5 b_ack", bus.b_ack, 1'b1);
        chk2("hold c5 gnt", gnt(), 2'b00);
        cyc(); chk2("hold c6 gnt", gnt(), 2'b10);
        chk16("hold c6 addr", bus.mem_address, 16'h0100);
        chk1("hold c6 b_ack", bus.b_ack, 1'b0);
        cyc(); set_a(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00); #1;
        chk1("hold c7 a_ack", bus.a_ack, 1'b1);
        chk8("hold c7 a_rdata", bus.a_rdata, 8'h11);
        chk2("hold c7 gnt", gnt(), 2'b00);
        cyc(); chk2("hold c8 gnt", gnt(), 2'b01);
        chk16("hold c8 addr", bus.mem_address, 16'h0014);
        chk1("hold c8 b_ack", bus.b_ack, 1'b0);
        cyc(); set_b(1'b1, 1'b1, 1'b1, 16'h0015, 8'hB5); #1;
        chk1("hold c9 b_ack", bus.b_ack, 1'b1);
        chk16("hold c9 addr", bus.mem_address, 16'h0015);
        cyc(); set_b(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00); #1;
        chk1("hold c10 b_ack", bus.b_ack, 1'b1);
        chk2("hold c10 gnt", gnt(), 2'b01);
        chk1("hold c10 we", bus.mem_write_en, 1'b0);
        cyc(); chk1("hold c11 b_ack", bus.b_ack, 1'b0);
        chk2("hold c11 gnt", gnt(), 2'b00);
        for (int i = 0; i < 6; i++) begin
            chk8("hold ram", ram[16'(16'h0010 + i)], 8'(8'hB0 + i));
        end

        // ---------------- B locked burst with A idle -----------------------
        cyc();
        set_b(1'b1, 1'b1, 1'b1, 16'h0030, 8'hC0);
        #1; chk2("burst c0 gnt", gnt(), 2'b00);
        cyc(); chk2("burst c1 gnt", gnt(), 2'b01);
        chk1("burst c1 we", bus.mem_write_en, 1'b1);
        for (int k = 1; k < 6; k++) begin
            cyc(); set_b(1'b1, 1'b1, 1'b1, 16'(16'h0030 + k), 8'(8'hC0 + k)); #1;
            chk1("burst b_ack", bus.b_ack, 1'b1);
            chk2("burst gnt", gnt(), 2'b01);
            chk1("burst we", bus.mem_write_en, 1'b1);
        end
        cyc(); set_b(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00); #1;
        chk1("burst c7 b_ack", bus.b_ack, 1'b1);
        chk2("burst c7 gnt", gnt(), 2'b01);
        chk1("burst c7 we", bus.mem_write_en, 1'b0);
        cyc(); chk1("burst c8 b_ack", bus.b_ack, 1'b0);
        chk2("burst c8 gnt", gnt(), 2'b00);
        cyc(); chk1("burst c9 b_ack", bus.b_ack, 1'b0);
        for (int i = 0; i < 6; i++) begin
            chk8("burst ram", ram[16'(16'h0030 + i)], 8'(8'hC0 + i));
        end

        // ---------------- reset during an A write --------------------------
        cyc();
        set_a(1'b1, 1'b1, 1'b0, 16'h0020, 8'hFF);
        #1; chk2("rstw c0 gnt", gnt(), 2'b00);
        cyc(); chk1("rstw c1 we", bus.mem_write_en, 1'b1);
        chk2("rstw c1 gnt", gnt(), 2'b10);
        reset_n = 1'b0;
        #1; chk1("rstw drop we", bus.mem_write_en, 1'b0);
        chk2("rstw drop gnt", gnt(), 2'b00);
        cyc(); chk8("rstw ram[20]", ram[16'h0020], 8'h5C);
        chk1("rstw c2 a_ack", bus.a_ack, 1'b0);
        set_a(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        reset_n = 1'b1;
        cyc(); chk1("rstw c3 a_ack", bus.a_ack, 1'b0);
        chk2("rstw c3 gnt", gnt(), 2'b00);
        cyc(); chk1("rstw c4 a_ack", bus.a_ack, 1'b0);
        chk8("rstw ram[20] after", ram[16'h0020], 8'h5C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
